// File: rtl/mem_dma_pkg.sv
// Shared definitions for the DMA copy engine and the memory it drives:
// default geometry and the controller state encoding.
package mem_dma_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dma.sv
// Memory-to-memory word copier with overlap-safe direction, address
// wrap-around and a running checksum of the copied words.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_dpra,
  input  logic [DATA_W-1:0] mem_dpo
);

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              desc_reg;
  logic              err_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] checksum_reg;
  logic [ADDR_W-1:0] a_reg;
  logic [ADDR_W-1:0] dpra_reg;

  logic [ADDR_W-1:0] diff;
  logic              len_ok;
  logic              dir_desc;
  logic [ADDR_W-1:0] first_idx;
  logic [ADDR_W-1:0] idx_next;
  logic              last_word;

  // Descend only when the destination starts inside the source range,
  // so every source word is read before it can be overwritten.
  assign diff      = dst_base - src_base;
  assign len_ok    = (len != '0) && (len <= MAX_LEN);
  assign dir_desc  = (diff != '0) && ({1'b0, diff} < len);
  assign first_idx = dir_desc ? (len[ADDR_W-1:0] - IDX_ONE) : '0;
  assign idx_next  = desc_reg ? (idx_reg - IDX_ONE) : (idx_reg + IDX_ONE);
  assign last_word = (cnt_reg == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = len_ok ? ST_READ : ST_DONE;
        end
      end
      ST_READ:  state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_DONE : ST_READ;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    mem_we = 1'b0;
    case (state_reg)
      ST_READ: begin
        busy = 1'b1;
      end
      ST_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_reg;
      end
      default: begin
      end
    endcase
  end

  // Address and data registers only move when the next phase needs them,
  // so the memory-side outputs hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      desc_reg     <= 1'b0;
      err_reg      <= 1'b0;
      data_reg     <= '0;
      checksum_reg <= '0;
      a_reg        <= '0;
      dpra_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            err_reg <= !len_ok && (len != '0);
            if (len_ok) begin
              src_reg      <= src_base;
              dst_reg      <= dst_base;
              cnt_reg      <= len;
              idx_reg      <= first_idx;
              desc_reg     <= dir_desc;
              checksum_reg <= '0;
              dpra_reg     <= src_base + first_idx;
            end
          end
        end
        ST_READ: begin
          data_reg     <= mem_dpo;
          checksum_reg <= checksum_reg + mem_dpo;
          a_reg        <= dst_reg + idx_reg;
        end
        ST_WRITE: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (!last_word) begin
            idx_reg  <= idx_next;
            dpra_reg <= src_reg + idx_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign checksum = checksum_reg;
  assign mem_a    = a_reg;
  assign mem_d    = data_reg;
  assign mem_dpra = dpra_reg;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: a word memory lives in the bench, and a
// reference model replays each command word by word to predict the result.
module tb_mem_dma;
  import mem_dma_pkg::*;

  localparam int AW    = ADDR_W_DEF;
  localparam int DW    = DATA_W_DEF;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] checksum;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [AW-1:0] mem_dpra;
  logic [DW-1:0] mem_dpo;

  mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_we   (mem_we),
    .mem_dpra (mem_dpra),
    .mem_dpo  (mem_dpo)
  );

  always #5 clk = ~clk;

  // Bench memory: async read, sync write, plus a preload port for the bench.
  typedef struct {
    int            e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] mem [DEPTH];
  logic          pl_we;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  int            edge_no = 0;
  wr_t           wr_log[$];

  assign mem_dpo = mem[mem_dpra];

  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    if (mem_we) begin
      mem[mem_a] <= mem_d;
      wr_log.push_back('{e: edge_no, a: mem_a, d: mem_d});
    end else if (pl_we) begin
      mem[pl_a] <= pl_d;
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_cks;
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    pl_we = 1'b1;
    pl_a  = AW'(a);
    pl_d  = d;
    ref_mem[AW'(a)] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic check_image(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[AW'(i)] !== ref_mem[AW'(i)]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_cks"}, checksum, 0);
    check({tag, "_a"}, 32'(mem_a), 0);
    check({tag, "_d"}, mem_d, 0);
    check({tag, "_dpra"}, 32'(mem_dpra), 0);
  endtask

  // Issues one command from a negedge and checks timing, writes, checksum and
  // the memory image. pulse_at > 0 injects a stray start mid-command.
  task automatic run_cmd(input string tag, input int src, input int dst, input int ln,
                         input int pulse_at);
    wr_t exp_q[$];
    int  eff, diff, e0, k, i, sa, da;
    bit  desc, rejected, seen;
    logic [DW-1:0] v;

    rejected = (ln > DEPTH);
    eff      = (ln >= 1 && ln <= DEPTH) ? ln : 0;
    if (eff > 0) begin
      ref_cks = '0;
      diff = (dst - src + DEPTH) % DEPTH;
      desc = (diff != 0) && (diff < ln);
      for (int j = 0; j < eff; j++) begin
        i  = desc ? (eff - 1 - j) : j;
        sa = (src + i) % DEPTH;
        da = (dst + i) % DEPTH;
        v  = ref_mem[AW'(sa)];
        ref_mem[AW'(da)] = v;
        ref_cks += v;
        exp_q.push_back('{e: 2 * j + 2, a: AW'(da), d: v});
      end
    end

    wr_log.delete();
    start    = 1'b1;
    src_base = AW'(src);
    dst_base = AW'(dst);
    len      = (AW + 1)'(ln);
    @(posedge clk);
    #1;
    e0       = edge_no - 1;
    start    = 1'b0;
    src_base = AW'($urandom);
    dst_base = AW'($urandom);
    len      = (AW + 1)'($urandom_range(1, 20));

    k    = 0;
    seen = 1'b0;
    while (k < 2 * eff + 20 && !seen) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else if (k == pulse_at) begin
        start    = 1'b1;
        src_base = AW'($urandom);
        dst_base = AW'($urandom);
        len      = (AW + 1)'($urandom_range(1, 6));
      end
    end
    start = 1'b0;

    check({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      check({tag, "_done_edge"}, edge_no - 1 - e0, 2 * eff);
      check({tag, "_err"}, 32'(err), 32'(rejected));
      check({tag, "_busy_done"}, 32'(busy), 1);
      check({tag, "_cks"}, checksum, ref_cks);
      @(negedge clk);
      check({tag, "_idle_done"}, 32'(done), 0);
      check({tag, "_idle_busy"}, 32'(busy), 0);
    end

    check({tag, "_nwr"}, wr_log.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < wr_log.size(); j++) begin
      if (wr_log[j].a !== exp_q[j].a || wr_log[j].d !== exp_q[j].d
          || wr_log[j].e - e0 != exp_q[j].e) begin
        check({tag, "_wr_addr"}, 32'(wr_log[j].a), 32'(exp_q[j].a));
        check({tag, "_wr_data"}, wr_log[j].d, exp_q[j].d);
        check({tag, "_wr_edge"}, wr_log[j].e - e0, exp_q[j].e);
      end
    end
    check_image({tag, "_image"});
    $display("cmd %s src=%0d dst=%0d len=%0d writes=%0d checksum=%0h", tag, src, dst, ln,
             wr_log.size(), checksum);
  endtask

  initial begin
    logic [DW-1:0] old_w [4];
    int e0, k, src, dst, ln;

    rst_n    = 1'b0;
    start    = 1'b0;
    src_base = '0;
    dst_base = '0;
    len      = '0;
    pl_we    = 1'b0;
    pl_a     = '0;
    pl_d     = '0;
    ref_cks  = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Basic ascending copy.
    for (int i = 0; i < 4; i++) poke(i, DW'(i + 1));
    run_cmd("basic", 0, 100, 4, 0);
    check("basic_cks10", checksum, 10);
    check("basic_m103", mem[AW'(103)], 4);

    // Overlapping ranges force a descending copy.
    for (int i = 0; i < 5; i++) poke(10 + i, DW'(32'hA + i));
    run_cmd("overlap", 10, 12, 5, 0);
    check("overlap_m12", mem[AW'(12)], 32'hA);
    check("overlap_m16", mem[AW'(16)], 32'hE);

    // Address wrap at the top of memory.
    old_w[0] = ref_mem[AW'(1022)];
    old_w[1] = ref_mem[AW'(1023)];
    old_w[2] = ref_mem[AW'(0)];
    old_w[3] = ref_mem[AW'(1)];
    run_cmd("wrap", 1022, 0, 4, 0);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_m%0d", i), mem[AW'(i)], old_w[i]);

    // Zero-length and oversize commands.
    run_cmd("len0", 7, 300, 0, 0);
    run_cmd("len1025", 7, 300, 1025, 0);

    // Full-memory descending copy.
    run_cmd("full", 0, 1, DEPTH, 0);

    // Stray start in the middle of a copy.
    run_cmd("pulse", 400, 600, 6, 3);

    for (int n = 0; n < 15; n++) begin
      src = $urandom_range(0, DEPTH - 1);
      dst = $urandom_range(0, 1) ? (src + $urandom_range(0, 12)) % DEPTH
                                 : $urandom_range(0, DEPTH - 1);
      ln  = $urandom_range(0, 20);
      run_cmd($sformatf("rnd%0d", n), src, dst, ln, 0);
    end

    // Reset while the third word's write is pending.
    wr_log.delete();
    start    = 1'b1;
    src_base = AW'(200);
    dst_base = AW'(500);
    len      = (AW + 1)'(8);
    @(posedge clk);
    #1;
    e0    = edge_no - 1;
    start = 1'b0;
    k     = 0;
    while (edge_no - 1 < e0 + 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_we_before", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    ref_mem[AW'(500)] = ref_mem[AW'(200)];
    ref_mem[AW'(501)] = ref_mem[AW'(201)];
    ref_cks = '0;
    repeat (3) @(negedge clk);
    check("rst_nwr", wr_log.size(), 2);
    check_image("rst_image");
    $display("cmd rst_mid src=200 dst=500 len=8 writes=%0d", wr_log.size());
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_cmd("after_rst", 50, 60, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
